// File: rtl/wb_pkg.sv
// wb_pkg: constants and request type shared by the writeback controller.
//   REGS_NUM          architectural register count (x0 hard-wired zero)
//   REG_AW            register index width
//   STARVE_LIMIT_DEF  default consecutive-ALU-grant budget while loads wait
//   wb_req_t          {rd, data} writeback request at the default data width
//   reg_onehot()      register index -> one-hot busy mask
package wb_pkg;
  localparam int REGS_NUM         = 32;
  localparam int REG_AW           = 5;
  localparam int DATA_W_DEF       = 32;
  localparam int STARVE_LIMIT_DEF = 3;

  typedef struct packed {
    logic [REG_AW-1:0]     rd;
    logic [DATA_W_DEF-1:0] data;
  } wb_req_t;

  function automatic logic [REGS_NUM-1:0] reg_onehot(input logic [REG_AW-1:0] rd);
    return REGS_NUM'(1) << rd;
  endfunction
endpackage

// File: rtl/reg_writeback_ctrl_if.sv
// reg_writeback_ctrl_if: ALU / LSU / alloc request channels and the
// register-file write port of the writeback controller.
//   slave  modport - the controller (consumes i_*, drives o_*)
//   master modport - the pipeline side (drives i_*, observes o_*)
interface reg_writeback_ctrl_if #(
  parameter int DataWidth = 32
);
  import wb_pkg::*;

  logic                  i_alu_valid;
  logic [REG_AW-1:0]     i_alu_rd;
  logic [DataWidth-1:0]  i_alu_data;
  logic                  o_alu_ready;

  logic                  i_lsu_valid;
  logic [REG_AW-1:0]     i_lsu_rd;
  logic [DataWidth-1:0]  i_lsu_data;
  logic                  o_lsu_ready;

  logic                  i_alloc_valid;
  logic [REG_AW-1:0]     i_alloc_rd;
  logic [REGS_NUM-1:0]   o_busy;

  logic [REG_AW-1:0]     o_wreg;
  logic [DataWidth-1:0]  o_wdata;
  logic                  o_we;

  modport slave (
    input  i_alu_valid, i_alu_rd, i_alu_data,
    input  i_lsu_valid, i_lsu_rd, i_lsu_data,
    input  i_alloc_valid, i_alloc_rd,
    output o_alu_ready, o_lsu_ready, o_busy,
    output o_wreg, o_wdata, o_we
  );

  modport master (
    output i_alu_valid, i_alu_rd, i_alu_data,
    output i_lsu_valid, i_lsu_rd, i_lsu_data,
    output i_alloc_valid, i_alloc_rd,
    input  o_alu_ready, o_lsu_ready, o_busy,
    input  o_wreg, o_wdata, o_we
  );
endinterface

// File: rtl/wb_fifo.sv
// wb_fifo: synchronous FIFO holding load results awaiting the write port.
//   clk, rst    clock, synchronous active-high reset
//   push/wdata  enqueue (ignored while full)
//   pop         dequeue (ignored while empty)
//   head        oldest entry
//   full/empty  flags decoded from a registered occupancy count
// Push and pop may coincide; a pop while full frees the slot for the next
// cycle only, since full is derived from the registered count.
module wb_fifo #(
  parameter int Width = 37,
  parameter int Depth = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [Width-1:0] wdata,
  input  logic             pop,
  output logic [Width-1:0] head,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(Depth);

  logic [Width-1:0] mem [Depth];
  logic [AW-1:0]    wptr, rptr;
  logic [AW:0]      count;
  logic             do_push, do_pop;

  assign full    = (count == (AW+1)'(Depth));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

  // Depth is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/reg_writeback_ctrl.sv
// reg_writeback_ctrl: arbitrates ALU and buffered load results onto a single
// registered register-file write port.
//   i_clk, i_rst  clock, synchronous active-high reset
//   bus           reg_writeback_ctrl_if.slave (ALU/LSU/alloc channels,
//                 write port, busy scoreboard)
// ALU has priority, except that after StarveLimit consecutive ALU grants with
// loads waiting, one cycle is reserved for the load buffer head.
// Optional: define WB_SCOREBOARD_EN to build the per-register busy scoreboard;
// otherwise o_busy is tied to zero and the alloc channel is ignored.
module reg_writeback_ctrl #(
  parameter int DataWidth    = 32,
  parameter int LsuFifoDepth = 4,
  parameter int StarveLimit  = wb_pkg::STARVE_LIMIT_DEF
) (
  input logic                    i_clk,
  input logic                    i_rst,
  reg_writeback_ctrl_if.slave    bus
);
  import wb_pkg::*;

  // Same shape as wb_req_t, at this instance's data width.
  typedef struct packed {
    logic [REG_AW-1:0]    rd;
    logic [DataWidth-1:0] data;
  } req_t;

  localparam int CW = (StarveLimit > 1) ? $clog2(StarveLimit) : 1;

  req_t          lsu_req, head, win;
  logic [$bits(req_t)-1:0] head_bits;
  logic          full, empty;
  logic          force_lsu;
  logic [CW-1:0] starve_cnt;
  logic          grant_alu, grant_lsu, win_we;

  logic                 we;
  logic [REG_AW-1:0]    wreg;
  logic [DataWidth-1:0] wdata;

  assign lsu_req = '{rd: bus.i_lsu_rd, data: bus.i_lsu_data};
  assign head    = req_t'(head_bits);

  wb_fifo #(
    .Width ($bits(req_t)),
    .Depth (LsuFifoDepth)
  ) u_fifo (
    .clk   (i_clk),
    .rst   (i_rst),
    .push  (bus.i_lsu_valid),
    .wdata (lsu_req),
    .pop   (grant_lsu),
    .head  (head_bits),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    grant_alu = bus.i_alu_valid && !force_lsu;
    grant_lsu = !grant_alu && !empty;
    win       = grant_alu ? '{rd: bus.i_alu_rd, data: bus.i_alu_data} : head;
    // x0 writes are consumed but never reach the register file.
    win_we    = (grant_alu || grant_lsu) && (win.rd != '0);
  end

  assign bus.o_alu_ready = !force_lsu;
  assign bus.o_lsu_ready = !full;

  // Starvation guard: counts ALU grants while loads wait; on reaching the
  // limit the next cycle is reserved for the buffer head.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      starve_cnt <= '0;
      force_lsu  <= 1'b0;
    end else if (empty || grant_lsu) begin
      starve_cnt <= '0;
      force_lsu  <= 1'b0;
    end else if (grant_alu) begin
      if (starve_cnt == CW'(StarveLimit - 1)) begin
        starve_cnt <= '0;
        force_lsu  <= 1'b1;
      end else begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      we    <= 1'b0;
      wreg  <= '0;
      wdata <= '0;
    end else begin
      we <= win_we;
      if (grant_alu || grant_lsu) begin
        wreg  <= win.rd;
        wdata <= win.data;
      end
    end
  end

  assign bus.o_we    = we;
  assign bus.o_wreg  = wreg;
  assign bus.o_wdata = wdata;

`ifdef WB_SCOREBOARD_EN
  // Clear at the grant edge so the bit drops in the same cycle o_we shows
  // the write; a same-cycle alloc of that register re-sets it.
  logic [REGS_NUM-1:0] busy, busy_nxt;

  always_comb begin
    busy_nxt = busy;
    if (win_we)            busy_nxt = busy_nxt & ~reg_onehot(win.rd);
    if (bus.i_alloc_valid) busy_nxt = busy_nxt |  reg_onehot(bus.i_alloc_rd);
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) busy <= '0;
    else       busy <= busy_nxt;
  end

  assign bus.o_busy = busy;
`else
  logic unused_alloc;
  assign unused_alloc = ^{bus.i_alloc_valid, bus.i_alloc_rd};
  assign bus.o_busy   = '0;
`endif
endmodule

// File: tb/tb_reg_writeback_ctrl.sv
// tb_reg_writeback_ctrl: directed vectors with hand-derived expectations for
// reg_writeback_ctrl (DataWidth=32, depth 4, StarveLimit 3).
module tb_reg_writeback_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  reg_writeback_ctrl_if #(.DataWidth(32)) bus ();

  reg_writeback_ctrl #(
    .DataWidth    (32),
    .LsuFifoDepth (4),
    .StarveLimit  (3)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive and sample 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int          a_cnt, l_cnt;
    logic [31:0] q[$];
    logic [31:0] exp_d;
    logic [4:0]  exp_rd;
    bit          ar_t[12] = '{1,1,1,1,0,1,1,1,0,1,1,1};
    bit          lr_t[12] = '{1,1,1,1,0,1,0,0,0,1,0,0};

    rst = 1'b1;
    bus.i_alu_valid = 0; bus.i_alu_rd = 0; bus.i_alu_data = 0;
    bus.i_lsu_valid = 0; bus.i_lsu_rd = 0; bus.i_lsu_data = 0;
    bus.i_alloc_valid = 0; bus.i_alloc_rd = 0;
    tick(); tick();
    chk("rst_we",    bus.o_we, 0);
    chk("rst_wreg",  bus.o_wreg, 0);
    chk("rst_wdata", bus.o_wdata, 0);
    chk("rst_busy",  bus.o_busy, 0);
    chk("rst_lsu_rdy", bus.o_lsu_ready, 1);
    rst = 1'b0;

    // ALU-only write
    bus.i_alu_valid = 1; bus.i_alu_rd = 5; bus.i_alu_data = 32'hDEADBEEF;
    chk("alu_rdy", bus.o_alu_ready, 1);
    tick();
    bus.i_alu_valid = 0;
    chk("alu_we",    bus.o_we, 1);
    chk("alu_wreg",  bus.o_wreg, 5);
    chk("alu_wdata", bus.o_wdata, 32'hDEADBEEF);
    tick();
    chk("alu_idle_we", bus.o_we, 0);

    // x0 write is consumed but suppressed
    bus.i_alu_valid = 1; bus.i_alu_rd = 0; bus.i_alu_data = 32'h1234;
    chk("x0_rdy", bus.o_alu_ready, 1);
    tick();
    bus.i_alu_valid = 0;
    chk("x0_we", bus.o_we, 0);
    tick();

    // Scoreboard: set wins over same-cycle clear
`ifdef WB_SCOREBOARD_EN
    bus.i_alloc_valid = 1; bus.i_alloc_rd = 7;
    tick();
    chk("sb_set", bus.o_busy[7], 1);
    bus.i_alu_valid = 1; bus.i_alu_rd = 7; bus.i_alu_data = 32'h77;
    tick();
    chk("sb_we7",  bus.o_we, 1);
    chk("sb_hold", bus.o_busy[7], 1);
    bus.i_alloc_valid = 0;
    tick();
    bus.i_alu_valid = 0;
    chk("sb_clr", bus.o_busy[7], 0);
    bus.i_alloc_valid = 1; bus.i_alloc_rd = 0;
    tick();
    bus.i_alloc_valid = 0;
    chk("sb_x0", bus.o_busy, 0);
`else
    bus.i_alloc_valid = 1; bus.i_alloc_rd = 7;
    tick();
    bus.i_alloc_valid = 0;
    chk("sb_off", bus.o_busy, 0);
`endif
    tick();

    // Contention + full buffer: ALU rd=1 and LSU rd=2 valid every cycle
    a_cnt = 0; l_cnt = 0;
    bus.i_alu_valid = 1; bus.i_alu_rd = 1; bus.i_alu_data = 32'hA0000000;
    bus.i_lsu_valid = 1; bus.i_lsu_rd = 2; bus.i_lsu_data = 32'hB0000000;
    for (int t = 0; t < 12; t++) begin
      chk($sformatf("ct_alu_rdy%0d", t), bus.o_alu_ready, ar_t[t]);
      chk($sformatf("ct_lsu_rdy%0d", t), bus.o_lsu_ready, lr_t[t]);
      if (ar_t[t]) begin
        exp_rd = 1; exp_d = 32'hA0000000 + a_cnt;
      end else begin
        exp_rd = 2; exp_d = q.pop_front();
      end
      if (lr_t[t]) q.push_back(32'hB0000000 + l_cnt);
      tick();
      chk($sformatf("ct_we%0d", t),    bus.o_we, 1);
      chk($sformatf("ct_wreg%0d", t),  bus.o_wreg, exp_rd);
      chk($sformatf("ct_wdata%0d", t), bus.o_wdata, exp_d);
      if (ar_t[t]) a_cnt++;
      if (lr_t[t]) l_cnt++;
      bus.i_alu_data = 32'hA0000000 + a_cnt;
      bus.i_lsu_data = 32'hB0000000 + l_cnt;
    end

    // Drain the 4 remaining loads in order
    bus.i_alu_valid = 0; bus.i_lsu_valid = 0;
    chk("dr_alu_rdy", bus.o_alu_ready, 0);
    for (int k = 0; k < 4; k++) begin
      exp_d = q.pop_front();
      tick();
      chk($sformatf("dr_wreg%0d", k),  bus.o_wreg, 2);
      chk($sformatf("dr_wdata%0d", k), bus.o_wdata, exp_d);
    end
    chk("dr_lsu_rdy", bus.o_lsu_ready, 1);
    tick();
    chk("dr_idle_we", bus.o_we, 0);

    // Reset mid-run with 3 loads buffered
    bus.i_alu_valid = 1; bus.i_alu_rd = 3; bus.i_alu_data = 32'hC0;
    bus.i_lsu_valid = 1; bus.i_lsu_rd = 4; bus.i_lsu_data = 32'hD0;
    tick(); tick();
    bus.i_alloc_valid = 1; bus.i_alloc_rd = 9;
    tick();
    bus.i_alloc_valid = 0; bus.i_alu_valid = 0; bus.i_lsu_valid = 0;
`ifdef WB_SCOREBOARD_EN
    chk("mr_busy_pre", bus.o_busy[9], 1);
`endif
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mr_we",      bus.o_we, 0);
    chk("mr_wreg",    bus.o_wreg, 0);
    chk("mr_busy",    bus.o_busy, 0);
    chk("mr_lsu_rdy", bus.o_lsu_ready, 1);
    tick();
    chk("mr_we1", bus.o_we, 0);
    tick();
    chk("mr_we2", bus.o_we, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/reg_writeback_ctrl.md
REG_WRITEBACK_CTRL -- requirements
Module: reg_writeback_ctrl

Interface
REQ-001 SHALL have parameter DataWidth, default 32, meaning width of writeback data.
REQ-002 SHALL have parameter LsuFifoDepth, default 4 (power of two, 2..16), meaning depth of the load-result buffer.
REQ-003 SHALL have parameter StarveLimit, default 3, meaning consecutive ALU grants allowed while the buffer is non-empty.
REQ-004 SHALL have ports (name  direction  width  meaning), clock and reset first:
- i_clk  in  1  single clock, all logic on rising edge.
- i_rst  in  1  reset, synchronous and active-high.
- i_alu_valid  in  1  ALU result offered.
- i_alu_rd  in  5  ALU destination register.
- i_alu_data  in  DataWidth  ALU result.
- o_alu_ready  out  1  ALU result accepted this cycle.
- i_lsu_valid  in  1  load result offered.
- i_lsu_rd  in  5  load destination register.
- i_lsu_data  in  DataWidth  load result.
- o_lsu_ready  out  1  buffer can accept a load result.
- i_alloc_valid  in  1  issue stage claims a destination register.
- i_alloc_rd  in  5  claimed register.
- o_busy  out  32  per-register pending-write bits.
- o_wreg  out  5  register-file write address.
- o_wdata  out  DataWidth  register-file write data.
- o_we  out  1  register-file write enable.

Function
REQ-005 SHALL transfer a request when valid and ready are both high on a rising edge; valid is never gated by ready.
REQ-006 SHALL buffer accepted LSU requests in a FIFO; o_lsu_ready = not full, independent of i_lsu_valid.
REQ-007 SHALL select each cycle: ALU if i_alu_valid and not forced-LSU; else FIFO head if non-empty; else none.
REQ-008 SHALL drive o_alu_ready high exactly when the ALU would win arbitration, regardless of i_alu_valid.
REQ-009 SHALL count consecutive ALU grants while the FIFO is non-empty; on reaching StarveLimit, next cycle is forced-LSU (o_alu_ready low), then the counter clears.
REQ-010 SHALL clear the starvation counter whenever the FIFO is empty or an LSU entry is written.
REQ-011 SHALL register the write port: the winner appears on o_wreg/o_wdata/o_we exactly one cycle after grant.
REQ-012 SHALL drop writes to register 0 (o_we low) while still consuming the request.
REQ-013 SHALL allow FIFO push and pop in the same cycle, including when full (pop frees the slot only for next cycle; o_lsu_ready remains low that cycle).
REQ-014 SHALL, with the scoreboard enabled, set o_busy[rd] on an alloc and clear o_busy[rd] in the cycle o_we is driven for rd.
REQ-015 SHALL give set priority over clear when alloc and writeback target the same register in one cycle.
REQ-016 SHALL hold o_busy[0] at 0 always.

Reset
REQ-017 SHALL on i_rst: o_we=0, o_wreg=0, o_wdata=0, o_busy=0, FIFO empty, starvation counter 0, o_lsu_ready=1 next cycle.
REQ-018 SHALL discard buffered and in-flight requests when reset is asserted mid-operation; no write is emitted in the cycle after reset.

Configuration
REQ-019 SHALL use macro WB_SCOREBOARD_EN: defined -> o_busy behaves per REQ-014..016; undefined -> o_busy tied to 0, i_alloc_* ignored, no scoreboard flops.

Structure
REQ-020 SHALL place in a shared package wb_pkg: REGS_NUM=32, request typedef wb_req_t {rd[4:0], data[DataWidth-1:0]}, default StarveLimit constant.
REQ-021 SHALL implement the LSU buffer as sub-module wb_fifo (synchronous, registered count, full/empty flags).

Verification
REQ-022 ALU-only: alu rd=5 data=0xDEADBEEF valid one cycle -> o_we=1, o_wreg=5, o_wdata=0xDEADBEEF next cycle.
REQ-023 Contention: ALU and LSU valid continuously, StarveLimit=3 -> grant pattern ALU,ALU,ALU,LSU repeating; o_alu_ready low on each LSU slot.
REQ-024 Full buffer: ALU valid continuously, 5 LSU pushes with depth 4 -> o_lsu_ready low after 4th push until first pop; no entry lost or reordered.
REQ-025 x0 write: alu rd=0 data=0x1234 -> o_alu_ready=1, o_we stays 0.
REQ-026 Scoreboard: alloc rd=7 then ALU write rd=7 with simultaneous alloc rd=7 -> o_busy[7] stays 1; lone write afterwards -> o_busy[7]=0.
REQ-027 Reset mid-run: 3 entries buffered, i_rst one cycle -> o_we=0 next cycle, o_busy=0, o_lsu_ready=1, no buffered entry written.
